// File: rtl/mult_div_unit_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op encodings,
// fixed latencies and the sequencer state type.
package mult_div_unit_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: results are computed combinationally from latched
// operands, and a down-counter models the fixed pipeline latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MD_START,
  input  logic [3:0]  MD_OP,
  input  logic [31:0] MD_A,
  input  logic [31:0] MD_B,
  input  logic        REQ,
  output logic        MULT_DIV_BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_RD
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept;
  logic [63:0] a_sext, b_sext, prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quot, rem;

  assign a_sext = {{32{a_q[31]}}, a_q};
  assign b_sext = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg = (op_q == OP_DIV) && a_q[31];
  assign b_neg = (op_q == OP_DIV) && b_q[31];
  assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
  assign uq    = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign ur    = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  assign MULT_DIV_BUSY = (state_q != ST_IDLE);
  assign accept        = MD_START && !REQ && !MULT_DIV_BUSY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (MD_OP)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL_RUN;
              cnt_d   = 4'(MUL_LAT);
              op_d    = MD_OP;
              a_d     = MD_A;
              b_d     = MD_B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_DIV_RUN;
              cnt_d   = 4'(DIV_LAT);
              op_d    = MD_OP;
              a_d     = MD_A;
              b_d     = MD_B;
            end
            OP_MTHI: hi_d = MD_A;
            OP_MTLO: lo_d = MD_A;
            default: ;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (op_q == OP_MULT) {hi_d, lo_d} = prod_s;
          else                 {hi_d, lo_d} = prod_u;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DIV_RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  always_comb begin
    MD_RD = '0;
    if (MD_OP == OP_MFHI)      MD_RD = hi_q;
    else if (MD_OP == OP_MFLO) MD_RD = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table through a scoreboard queue, then
// hand sequences for cancel, busy-time behaviour and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MD_START = 1'b0;
  logic [3:0]  MD_OP = OP_NONE;
  logic [31:0] MD_A = '0;
  logic [31:0] MD_B = '0;
  logic        REQ = 1'b0;
  logic        MULT_DIV_BUSY;
  logic [31:0] HI, LO, MD_RD;

  mult_div_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MD_START      (MD_START),
    .MD_OP         (MD_OP),
    .MD_A          (MD_A),
    .MD_B          (MD_B),
    .REQ           (REQ),
    .MULT_DIV_BUSY (MULT_DIV_BUSY),
    .HI            (HI),
    .LO            (LO),
    .MD_RD         (MD_RD)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int unsigned lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi, lo;
    int unsigned lat;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] cur_hi, cur_lo;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] hi,
                              input logic [31:0] lo, input int unsigned lat);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    @(negedge clk);
    MD_START = 1'b1; MD_OP = op; MD_A = a; MD_B = b; REQ = rq;
    @(posedge clk);
    #1;
    MD_START = 1'b0; MD_OP = OP_NONE; REQ = 1'b0;
  endtask

  // Count busy cycles sampled on falling edges, bounded so a stuck BUSY ends.
  task automatic measure(output int unsigned lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!MULT_DIV_BUSY) break;
      lat++;
    end
  endtask

  initial begin
    int unsigned l;
    exp_t        e;

    add("mult_neg1x2",   OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    add("multu_maxx2",   OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5);
    add("div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    add("div_ovf",       OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    add("divu_256_7",    OP_DIVU,  32'd256,      32'd7,        32'h00000004, 32'h00000024, 10);
    add("div_7_m2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    add("div_m8_3",      OP_DIV,   32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE, 10);
    add("mult_min_sq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);
    add("multu_max_sq",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    add("mthi",          OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h00000001, 0);
    add("mtlo",          OP_MTLO,  32'h0000ABCD, 32'd0,        32'h00001234, 32'h0000ABCD, 0);
    add("divu_by0",      OP_DIVU,  32'd5,        32'd0,        32'h00001234, 32'h0000ABCD, 10);
    add("div_by0",       OP_DIV,   32'h80000000, 32'd0,        32'h00001234, 32'h0000ABCD, 10);
    add("op_none",       OP_NONE,  32'h11111111, 32'd3,        32'h00001234, 32'h0000ABCD, 0);
    add("op_mfhi",       OP_MFHI,  32'h22222222, 32'd3,        32'h00001234, 32'h0000ABCD, 0);
    add("op_15",         4'd15,    32'h33333333, 32'd3,        32'h00001234, 32'h0000ABCD, 0);
    add("mult_7_m3",     OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    add("multu_7_m3",    OP_MULTU, 32'd7,        32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 5);

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, MULT_DIV_BUSY}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      e.name = vecs[i].name; e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.lat = vecs[i].lat;
      sb.push_back(e);
      measure(l);
      e = sb.pop_front();
      check({e.name, "_lat"}, l, e.lat);
      check({e.name, "_hi"}, HI, e.hi);
      check({e.name, "_lo"}, LO, e.lo);
    end
    cur_hi = 32'h00000006;
    cur_lo = 32'hFFFFFFEB;

    // Start cancelled by a same-cycle exception request.
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b1);
    @(negedge clk);
    check("cancel_busy", {31'd0, MULT_DIV_BUSY}, 32'd0);
    check("cancel_hi", HI, cur_hi);
    check("cancel_lo", LO, cur_lo);

    MD_OP = OP_MFHI; #1 check("mfhi_rd", MD_RD, cur_hi);
    MD_OP = OP_MFLO; #1 check("mflo_rd", MD_RD, cur_lo);
    MD_OP = OP_MTHI; #1 check("mthi_rd", MD_RD, 32'd0);
    MD_OP = OP_NONE;

    // Busy window: old LO readable, new start and REQ both ignored.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd3, 1'b0);
    MD_OP = OP_MFLO;
    @(negedge clk);
    check("busy_c1", {31'd0, MULT_DIV_BUSY}, 32'd1);
    check("busy_rd_old", MD_RD, cur_lo);
    MD_START = 1'b1; MD_OP = OP_MTLO; MD_A = 32'hDEADBEEF; REQ = 1'b1;
    @(negedge clk);
    check("busy_c2", {31'd0, MULT_DIV_BUSY}, 32'd1);
    MD_START = 1'b0; MD_OP = OP_NONE; REQ = 1'b0;
    measure(l);
    check("busy_rest_lat", l, 32'd3);
    check("busy_hi", HI, 32'h00000002);
    check("busy_lo", LO, 32'hFFFFFFFD);

    // Reset in the third busy cycle of a divide, then a command on the first edge.
    issue(OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, MULT_DIV_BUSY}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, MULT_DIV_BUSY}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    MD_START = 1'b1; MD_OP = OP_MTLO; MD_A = 32'h55;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    MD_START = 1'b0; MD_OP = OP_NONE;
    check("post_rst_lo", LO, 32'h55);
    check("post_rst_hi", HI, 32'd0);
    @(negedge clk);
    check("post_rst_busy", {31'd0, MULT_DIV_BUSY}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk is the single clock; rst_n is the active-low asynchronous reset.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 MD_START  input  1  one-cycle request from the EX stage to execute MD_OP.
REQ-005 MD_OP  input  4  operation code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
REQ-006 MD_A  input  32  forwarded rs operand.
REQ-007 MD_B  input  32  forwarded rt operand.
REQ-008 REQ  input  1  exception/interrupt request; cancels the EX-stage instruction this cycle.
REQ-009 MULT_DIV_BUSY  output  1  an operation is in progress; drives the ID-stage stall.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.
REQ-012 MD_RD  output  32  read data for MFHI/MFLO.

Function
REQ-013 SHALL accept a command only when MD_START=1, REQ=0 and MULT_DIV_BUSY=0; all other cycles leave state unchanged.
REQ-014 SHALL, on an accepted MULT/MULTU/DIV/DIVU, latch MD_A, MD_B and MD_OP at that edge.
REQ-015 SHALL then hold MULT_DIV_BUSY=1 for exactly 5 cycles (MULT/MULTU) or 10 cycles (DIV/DIVU), starting the cycle after acceptance.
REQ-016 SHALL write HI/LO at the edge where MULT_DIV_BUSY falls, so the new values are visible in the first non-busy cycle.
REQ-017 SHALL implement three states: IDLE, MUL_RUN, DIV_RUN, with a down-counter; IDLE->RUN on accept, RUN->IDLE when the counter reaches 1.
REQ-018 MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
REQ-019 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-020 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divide by zero (DIV/DIVU with latched MD_B=0) SHALL run the full 10 busy cycles and leave HI/LO unchanged.
REQ-023 An accepted MTHI/MTLO SHALL write MD_A into HI/LO at the next edge with no busy cycles.
REQ-024 MD_RD SHALL be combinational: HI when MD_OP=MFHI, LO when MD_OP=MFLO, else 0; during busy it shows the pre-operation HI/LO.
REQ-025 MD_START while busy SHALL be ignored (the hazard stall guarantees this case does not occur; ignoring it is the defined behaviour).
REQ-026 REQ rising while busy SHALL NOT abort the operation; the instruction has already committed past EX.
REQ-027 MD_START with MD_OP in {NONE, MFHI, MFLO, 9..15} SHALL NOT change state.

Reset
REQ-028 rst_n=0 SHALL immediately force MULT_DIV_BUSY=0, HI=0, LO=0, state IDLE and counter 0, including mid-operation; the pending result is discarded.
REQ-029 After rst_n deasserts, the first command SHALL be acceptable on the first rising edge.

Structure
REQ-030 The MD_OP encodings and the latency constants (MUL_LAT=5, DIV_LAT=10) SHALL live in the shared pipeline package used by the decoder and the hazard controller.
REQ-031 Products and quotients SHALL be computed combinationally from the latched operands; the latency is modelled by the counter only.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 MULT with A=0xFFFFFFFF, B=2 -> BUSY high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 MULTU with A=0xFFFFFFFF, B=2 -> BUSY high 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 DIV with A=0xFFFFFFF9 (-7), B=2 -> BUSY high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 MTHI with A=0x1234, then DIVU with B=0 -> BUSY high 10 cycles, then HI=0x1234 and LO unchanged; MFHI gives MD_RD=0x1234.
REQ-037 MULT with MD_START=1 and REQ=1 in the same cycle -> BUSY stays 0 and HI/LO are unchanged.
REQ-038 rst_n pulsed low in busy cycle 3 of a DIV -> BUSY=0, HI=0, LO=0 immediately; a following MTLO 0x55 gives LO=0x55.
